seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 13 +
 rtl/seq_divider_if.sv | 28 ++
 rtl/seq_divider_subtractor.sv | 14 +
 rtl/seq_divider.sv | 129 ++++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between a divider client (master) and the divider (slave).
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_subtractor.sv
// The ALU subtractor reused by the divider: a - b with a signed-overflow flag.
module seq_divider_subtractor #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_ovf
);

  assign o_diff = i_a - i_b;
  assign o_ovf  = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (o_diff[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// A zero divisor skips the iteration and reports all-ones quotient with the dividend as remainder.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_dbz;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_dvs_zero;
  logic             w_last_step;
  logic             w_qbit;
  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH:0]   w_borrow_chk;
  logic             w_ovf_unused;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_dvs_zero  = (bus.divisor == {WIDTH{1'b0}});
  assign w_last_step = (r_cnt == CNT_ONE);
  assign w_trial     = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};

  // Unsigned trial >= divisor via a 65-bit borrow; a set R MSB means the trial already exceeds 2^64.
  assign w_borrow_chk = {1'b0, w_trial} - {1'b0, r_dvs};
  assign w_qbit       = r_rem[WIDTH-1] | ~w_borrow_chk[WIDTH];

  seq_divider_subtractor #(.WIDTH(WIDTH)) u_subtractor (
    .i_a   (w_trial),
    .i_b   (r_dvs),
    .o_diff(w_diff),
    .o_ovf (w_ovf_unused)
  );

  // Next-state decode for the IDLE/BUSY/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_dvs_zero ? DONE : BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (w_last_step) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand capture on accept, then one restoring step per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_dvd <= {WIDTH{1'b0}};
      r_dvs <= {WIDTH{1'b0}};
      r_rem <= {WIDTH{1'b0}};
      r_quo <= {WIDTH{1'b0}};
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= bus.dividend;
      r_dvs <= bus.divisor;
      r_dbz <= w_dvs_zero;
      if (w_dvs_zero) begin
        r_cnt <= {CNT_W{1'b0}};
        r_rem <= bus.dividend;
        r_quo <= {WIDTH{1'b1}};
      end else begin
        r_cnt <= CNT_LOAD;
        r_rem <= {WIDTH{1'b0}};
        r_quo <= {WIDTH{1'b0}};
      end
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt - CNT_ONE;
      r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
      r_rem <= w_qbit ? w_diff : w_trial;
      r_quo <= {r_quo[WIDTH-2:0], w_qbit};
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised scoreboard bench for seq_divider: the driver queues expected results from plain
// integer division, and a monitor pops and checks them whenever a result is presented.
module tb_seq_divider;

  localparam int W = 64;

  typedef struct {
    logic [63:0] quo;
    logic [63:0] rem;
    logic        dbz;
    int          acc;
    int          lat;
    int          stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a request, hold it until in_ready, and queue the expected result.
  task automatic send(input logic [63:0] dvd, input logic [63:0] dvs, input int stall,
                      output int acc);
    exp_t e;
    int   t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    t = 0;
    while (!bus.in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    acc = cyc + 1;
    if (!bus.in_ready) begin
      n_checks++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, want 1", t);
      bus.in_valid = 1'b0;
    end else begin
      e.quo   = (dvs == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : dvd / dvs;
      e.rem   = (dvs == 64'd0) ? dvd : dvd % dvs;
      e.dbz   = (dvs == 64'd0);
      e.lat   = (dvs == 64'd0) ? 1 : W + 1;
      e.acc   = acc;
      e.stall = stall;
      exp_q.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.dividend = {$urandom(), $urandom()};
      bus.divisor  = {$urandom(), $urandom()};
    end
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.in_ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending, want 0", exp_q.size());
    end
  endtask

  // Monitor: a negedge sample at cyc==n shows what the active edge n+1 will sample.
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_valid = 1'b0;
  bit   hs_prev = 1'b0;
  int   stall_left = 0;

  always @(negedge clk) begin
    if (hs_prev) begin
      check1("in_ready_after_handshake", bus.in_ready, 1'b1);
      check1("out_valid_after_handshake", bus.out_valid, 1'b0);
    end
    hs_prev = 1'b0;
    if (bus.out_valid === 1'b1) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_bad++;
          have_cur = 1'b0;
          stall_left = 0;
          $display("FAIL unexpected_out_valid: got 1 with no request pending, want 0 (cycle %0d)", cyc);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          stall_left = cur.stall;
          check("latency_cycle", 64'(cyc), 64'(cur.acc + cur.lat - 1));
          check("quotient", bus.quotient, cur.quo);
          check("remainder", bus.remainder, cur.rem);
          check1("div_by_zero", bus.div_by_zero, cur.dbz);
        end
      end else if (have_cur) begin
        check("quotient_held", bus.quotient, cur.quo);
        check("remainder_held", bus.remainder, cur.rem);
        check1("div_by_zero_held", bus.div_by_zero, cur.dbz);
      end
      check1("in_ready_while_valid", bus.in_ready, 1'b0);
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
        hs_prev = 1'b1;
      end
    end else begin
      bus.out_ready = 1'b0;
    end
    prev_valid = (bus.out_valid === 1'b1);
  end

  logic [63:0] d_dvd [7];
  logic [63:0] d_dvs [7];
  int          d_stall [7];

  initial begin
    int          acc;
    logic [63:0] dvd;
    logic [63:0] dvs;

    d_dvd   = '{64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 64'd55, 64'd1000, 64'hFFFF_FFFF_FFFF_FFFF};
    d_dvs   = '{64'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0001, 64'd0, 64'd33, 64'hFFFF_FFFF_FFFF_FFFE};
    d_stall = '{0, 0, 0, 0, 0, 5, 0};

    bus.in_valid = 1'b0;
    bus.dividend = 64'd0;
    bus.divisor  = 64'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check1("reset_in_ready", bus.in_ready, 1'b1);
    check1("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_quotient", bus.quotient, 64'd0);
    check("reset_remainder", bus.remainder, 64'd0);
    check1("reset_div_by_zero", bus.div_by_zero, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) send(d_dvd[i], d_dvs[i], d_stall[i], acc);

    for (int i = 0; i < 40; i++) begin
      dvd = {$urandom(), $urandom()};
      case ($urandom_range(0, 4))
        0: dvs = {$urandom(), $urandom()};
        1: dvs = 64'($urandom_range(1, 255));
        2: dvs = 64'd0;
        3: dvs = dvd + 64'($urandom_range(1, 1000));
        default: begin
          dvd[63] = 1'b1;
          dvs = {1'b1, $urandom(), 31'($urandom())};
        end
      endcase
      send(dvd, dvs, int'($urandom_range(0, 3)), acc);
    end
    drain();

    // Abort a request mid-iteration; its result must never appear.
    send(64'd123456789, 64'd1000, 0, acc);
    while (cyc < acc + 29) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check1("abort_in_ready", bus.in_ready, 1'b1);
    check1("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_quotient", bus.quotient, 64'd0);
    check("abort_remainder", bus.remainder, 64'd0);
    repeat (80) begin
      @(negedge clk);
      check1("abort_no_out_valid", bus.out_valid, 1'b0);
    end

    send(64'd100, 64'd7, 1, acc);
    send(64'd55, 64'd0, 0, acc);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
